// File: rtl/frac_lutk_arith_dbuf_tile.sv
// Fracturable LUT-K / arithmetic tile with a double-buffered scan configuration chain.
// Latency: datapath is combinational from the active config; ccff_tail lags ccff_head by CHAIN_LEN shifts.
// Backpressure: none; a commit is accepted only after exactly CHAIN_LEN shifts, otherwise commit_err pulses.
//
// Ports:
//   prog_clk, pReset (async, active-low)       clock and reset
//   config_enable, ccff_head, ccff_tail        serial configuration chain (shift into shadow)
//   commit, config_done, commit_err            shadow->active transfer and its status
//   cfg_valid                                  active config has been committed since reset
//   in, cin                                    LUT inputs and carry-in
//   lut_half_out, lut_out, cout                two LUT(K-1) outputs, LUT-K/sum output, carry-out
module frac_lutk_arith_dbuf_tile #(
  parameter int LUT_K     = 4,
  parameter int MODE_BITS = 2,
  parameter int CHAIN_LEN = 2**LUT_K + MODE_BITS,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 2)
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             config_enable,
  input  logic             ccff_head,
  input  logic             commit,
  input  logic [LUT_K-1:0] in,
  input  logic             cin,
  output logic [1:0]       lut_half_out,
  output logic             lut_out,
  output logic             cout,
  output logic             ccff_tail,
  output logic             config_done,
  output logic             cfg_valid,
  output logic             commit_err
);

  localparam int SRAM_N = 2**LUT_K;
  localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(CHAIN_LEN);
  // One past the chain length marks an over-shifted chain.
  localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] shadow;
  logic [CHAIN_LEN-1:0] active;
  logic [CNT_W-1:0]     count;
  logic                 commit_ok;

  // A commit during a shift cycle is always rejected, even if the count matches.
  assign commit_ok   = commit & ~config_enable & (count == LEN_CNT);
  assign config_done = (count == LEN_CNT);
  assign ccff_tail   = shadow[CHAIN_LEN-1];

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      shadow     <= '0;
      active     <= '0;
      count      <= '0;
      cfg_valid  <= 1'b0;
      commit_err <= 1'b0;
    end else begin
      if (config_enable) begin
        shadow <= {shadow[CHAIN_LEN-2:0], ccff_head};
      end
      // Any commit, accepted or not, forces a full reload before the next one.
      if (commit) begin
        count <= '0;
      end else if (config_enable && (count != SAT_CNT)) begin
        count <= count + CNT_W'(1);
      end
      if (commit_ok) begin
        active    <= shadow;
        cfg_valid <= 1'b1;
      end
      commit_err <= commit & ~commit_ok;
    end
  end

  // Datapath decode from the active configuration only, so reloading never glitches it.
  logic [SRAM_N-1:0]    sram;
  logic [MODE_BITS-1:0] mode;
  logic [LUT_K-2:0]     idx;
  logic                 h0;
  logic                 h1;
  logic                 carry;

  assign sram  = active[SRAM_N-1:0];
  assign mode  = active[SRAM_N +: MODE_BITS];
  assign idx   = in[LUT_K-2:0];
  assign h0    = sram[{1'b0, idx}];
  assign h1    = sram[{1'b1, idx}];
  assign carry = cin ^ mode[1];

  always_comb begin
    lut_half_out = 2'b00;
    lut_out      = 1'b0;
    cout         = 1'b0;
    if (cfg_valid) begin
      lut_half_out = {h1, h0};
      if (mode[0]) begin
        // Lower half acts as propagate, upper half as generate.
        lut_out = h0 ^ carry;
        cout    = h0 ? carry : h1;
      end else begin
        lut_out = in[LUT_K-1] ? h1 : h0;
      end
    end
  end

endmodule

// File: tb/tb_frac_lutk_arith_dbuf_tile.sv
module tb_frac_lutk_arith_dbuf_tile;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic       pReset;
  logic       ce0, ce1, cm0, cm1, head, cin;
  logic [3:0] in_v;
  logic [1:0] half0, half1;
  logic       out0, out1, cout0, cout1, tail0, tail1;
  logic       done0, done1, valid0, valid1, err0, err1;

  frac_lutk_arith_dbuf_tile u_t0 (
    .prog_clk(prog_clk), .pReset(pReset), .config_enable(ce0), .ccff_head(head),
    .commit(cm0), .in(in_v), .cin(cin), .lut_half_out(half0), .lut_out(out0),
    .cout(cout0), .ccff_tail(tail0), .config_done(done0), .cfg_valid(valid0),
    .commit_err(err0)
  );

  frac_lutk_arith_dbuf_tile u_t1 (
    .prog_clk(prog_clk), .pReset(pReset), .config_enable(ce1), .ccff_head(tail0),
    .commit(cm1), .in(in_v), .cin(cin), .lut_half_out(half1), .lut_out(out1),
    .cout(cout1), .ccff_tail(tail1), .config_done(done1), .cfg_valid(valid1),
    .commit_err(err1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one tile for K=4: {lut_half_out, lut_out, cout}.
  function automatic logic [3:0] model(input logic [17:0] cfg, input logic v,
                                       input logic [3:0] i, input logic c);
    logic [15:0] sram;
    logic [1:0]  mode;
    logic [2:0]  idx;
    logic        h0, h1, cc, lo, co;
    sram = cfg[15:0];
    mode = cfg[17:16];
    idx  = i[2:0];
    h0   = sram[{1'b0, idx}];
    h1   = sram[{1'b1, idx}];
    cc   = c ^ mode[1];
    if (mode[0]) begin
      lo = h0 ^ cc;
      co = h0 ? cc : h1;
    end else begin
      lo = i[3] ? h1 : h0;
      co = 1'b0;
    end
    if (!v) return 4'b0000;
    return {h1, h0, lo, co};
  endfunction

  typedef struct {
    int         tile;
    logic [3:0] exp;
  } sb_t;
  sb_t sb_q[$];

  logic [17:0] act0, act1;
  logic        v0, v1;

  task automatic apply(input logic [3:0] i, input logic c, input string tag);
    sb_t        e;
    logic [3:0] obs;
    in_v = i;
    cin  = c;
    sb_q.push_back('{tile: 0, exp: model(act0, v0, i, c)});
    sb_q.push_back('{tile: 1, exp: model(act1, v1, i, c)});
    #1;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = (e.tile == 0) ? {half0, out0, cout0} : {half1, out1, cout1};
      chk($sformatf("%s_t%0d_in%0h_c%0d", tag, e.tile, i, c), {28'd0, obs}, {28'd0, e.exp});
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 2; c++) begin
        apply(i[3:0], c[0], tag);
      end
    end
    @(negedge prog_clk);
  endtask

  task automatic step(input logic b, input logic e0, input logic e1,
                      input logic c0, input logic c1);
    head = b; ce0 = e0; ce1 = e1; cm0 = c0; cm1 = c1;
    @(negedge prog_clk);
    head = 1'b0; ce0 = 1'b0; ce1 = 1'b0; cm0 = 1'b0; cm1 = 1'b0;
  endtask

  task automatic load0(input logic [17:0] cfg);
    for (int k = 0; k < 18; k++) step(cfg[17-k], 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_half0"}, {30'd0, half0}, 32'd0);
    chk({tag, "_out0"}, {31'd0, out0}, 32'd0);
    chk({tag, "_cout0"}, {31'd0, cout0}, 32'd0);
    chk({tag, "_tail0"}, {31'd0, tail0}, 32'd0);
    chk({tag, "_done0"}, {31'd0, done0}, 32'd0);
    chk({tag, "_valid0"}, {31'd0, valid0}, 32'd0);
    chk({tag, "_err0"}, {31'd0, err0}, 32'd0);
    chk({tag, "_valid1"}, {31'd0, valid1}, 32'd0);
    chk({tag, "_out1"}, {31'd0, out1}, 32'd0);
    chk({tag, "_tail1"}, {31'd0, tail1}, 32'd0);
  endtask

  logic [17:0] cfg_x, cfg_a, cfg_b, cfg_c;
  logic [35:0] s;

  initial begin
    pReset = 1'b0;
    ce0 = 1'b0; ce1 = 1'b0; cm0 = 1'b0; cm1 = 1'b0; head = 1'b0;
    in_v = 4'd0; cin = 1'b0;
    act0 = '0; act1 = '0; v0 = 1'b0; v1 = 1'b0;

    // Reset state
    #1;
    chk_all_zero("reset");
    @(negedge prog_clk);
    @(negedge prog_clk);
    pReset = 1'b1;
    @(negedge prog_clk);
    chk_all_zero("post_reset");

    // XOR4 load and commit
    cfg_x = {2'b00, 16'h6996};
    load0(cfg_x);
    chk("xor_done_before_commit", {31'd0, done0}, 32'd1);
    chk("xor_valid_before_commit", {31'd0, valid0}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    act0 = cfg_x; v0 = 1'b1;
    chk("xor_valid_after_commit", {31'd0, valid0}, 32'd1);
    chk("xor_err_after_commit", {31'd0, err0}, 32'd0);
    chk("xor_done_cleared", {31'd0, done0}, 32'd0);
    in_v = 4'b0111; cin = 1'b0; #1;
    chk("xor_in0111", {31'd0, out0}, 32'd1);
    in_v = 4'b1111; #1;
    chk("xor_in1111", {31'd0, out0}, 32'd0);
    sweep("xor4");

    // Arithmetic mode, then carry-in inversion
    cfg_a = {2'b01, 8'h00, 8'hAA};
    load0(cfg_a);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    act0 = cfg_a;
    in_v = 4'b0001; cin = 1'b1; #1;
    chk("arith_sum_p1c1", {31'd0, out0}, 32'd0);
    chk("arith_cout_p1c1", {31'd0, cout0}, 32'd1);
    cin = 1'b0; #1;
    chk("arith_sum_p1c0", {31'd0, out0}, 32'd1);
    chk("arith_cout_p1c0", {31'd0, cout0}, 32'd0);
    sweep("arith");
    cfg_a = {2'b11, 8'h00, 8'hAA};
    load0(cfg_a);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    act0 = cfg_a;
    in_v = 4'b0001; cin = 1'b0; #1;
    chk("cinv_sum", {31'd0, out0}, 32'd0);
    chk("cinv_cout", {31'd0, cout0}, 32'd1);
    sweep("arith_cinv");

    // Short chain: 17 shifts then commit is rejected
    for (int k = 0; k < 17; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("short_done", {31'd0, done0}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("short_err", {31'd0, err0}, 32'd1);
    chk("short_valid_kept", {31'd0, valid0}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("short_err_one_cycle", {31'd0, err0}, 32'd0);
    chk("short_count_cleared", {31'd0, done0}, 32'd0);
    sweep("short_active_kept");
    // Long chain: count is 1, reach 18 then 19
    for (int k = 0; k < 17; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("long_done_at_len", {31'd0, done0}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("long_done_falls", {31'd0, done0}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("long_err", {31'd0, err0}, 32'd1);
    sweep("long_active_kept");

    // Two chained tiles; tile1 receives the first 18 bits through tile0
    cfg_a = {2'b00, 16'h8000};
    cfg_b = {2'b01, 16'h0F55};
    for (int k = 0; k < 18; k++) s[k] = cfg_b[17-k];
    for (int k = 18; k < 36; k++) s[k] = cfg_a[35-k];
    for (int k = 0; k < 36; k++) begin
      // Shift+commit on tile0's 18th shift is rejected and restarts its count.
      step(s[k], 1'b1, (k >= 18), (k == 17), 1'b0);
      if (k == 17) chk("chain_shift_commit_err", {31'd0, err0}, 32'd1);
      if (k >= 17) chk($sformatf("chain_tail0_k%0d", k), {31'd0, tail0}, {31'd0, s[k-17]});
    end
    chk("chain_tail1", {31'd0, tail1}, {31'd0, s[0]});
    chk("chain_done0", {31'd0, done0}, 32'd1);
    chk("chain_done1", {31'd0, done1}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    act0 = cfg_a; act1 = cfg_b; v1 = 1'b1;
    chk("chain_valid0", {31'd0, valid0}, 32'd1);
    chk("chain_valid1", {31'd0, valid1}, 32'd1);
    chk("chain_err0", {31'd0, err0}, 32'd0);
    chk("chain_err1", {31'd0, err1}, 32'd0);
    sweep("chain");

    // Reload while active: old function holds until the commit edge
    cfg_c = {2'b00, 16'h0001};
    for (int k = 0; k < 18; k++) begin
      step(cfg_c[17-k], 1'b1, 1'b0, 1'b0, 1'b0);
      if (k % 6 == 5) apply(4'(k), k[0], "hold_old");
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    act0 = cfg_c;
    sweep("reloaded");

    // Reset asserted mid-shift clears everything at once
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    head = 1'b1; ce0 = 1'b1; ce1 = 1'b1;
    #2;
    pReset = 1'b0;
    #1;
    act0 = '0; act1 = '0; v0 = 1'b0; v1 = 1'b0;
    chk_all_zero("mid_shift_reset");
    apply(4'b0000, 1'b0, "reset_dp");
    apply(4'b1111, 1'b1, "reset_dp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
